// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes and
// datapath select codes (aluop codes are also consumed by alucont).
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       irwrite;
        logic       alusrca;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic [1:0] alusrcb;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_legal_op = 1'b1;
            default:                                       is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decoder: maps the current state to datapath strobes/selects.
// Only the FETCH irwrite/pcwrite strobes depend on an input (mem_ready).
module mc_outdec
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH2;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsource = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: state register, next-state logic with memory
// wait states, and the retired-instruction counter.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        pcwritecond,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        irwrite,
    output logic        alusrca,
    output logic        regwrite,
    output logic        regdst,
    output logic [1:0]  pcsource,
    output logic [1:0]  aluop,
    output logic [1:0]  alusrcb,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [3:0]  state
);

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;
    ctrl_t       ctrl_raw;
    ctrl_t       ctrl;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
        instret_d = instret_q + {31'b0, retire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    mc_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Reset blanks every output combinationally, even when the state register
    // still holds a stale MEMWR from before reset was raised.
    always_comb begin
        ctrl    = reset ? '0 : ctrl_raw;
        illegal = !reset && (state_q == S_DECODE) && !is_legal_op(opcode);
        state   = reset ? '0 : state_q;
        instret = reset ? '0 : instret_q;
    end

    assign pcwrite     = ctrl.pcwrite;
    assign pcwritecond = ctrl.pcwritecond;
    assign iord        = ctrl.iord;
    assign memread     = ctrl.memread;
    assign memwrite    = ctrl.memwrite;
    assign memtoreg    = ctrl.memtoreg;
    assign irwrite     = ctrl.irwrite;
    assign alusrca     = ctrl.alusrca;
    assign regwrite    = ctrl.regwrite;
    assign regdst      = ctrl.regdst;
    assign pcsource    = ctrl.pcsource;
    assign aluop       = ctrl.aluop;
    assign alusrcb     = ctrl.alusrcb;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state/strobe vectors per scenario.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic        irwrite, alusrca, regwrite, regdst, illegal;
    logic [1:0]  pcsource, aluop, alusrcb;
    logic [31:0] instret;
    logic [3:0]  state;
    logic [15:0] outs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rdy;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [15:0] outs;
        logic        ill;
        logic [31:0] ir;
    } vec_t;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .memtoreg    (memtoreg),
        .irwrite     (irwrite),
        .alusrca     (alusrca),
        .regwrite    (regwrite),
        .regdst      (regdst),
        .pcsource    (pcsource),
        .aluop       (aluop),
        .alusrcb     (alusrcb),
        .illegal     (illegal),
        .instret     (instret),
        .state       (state)
    );

    // {pcwrite,pcwritecond,iord,memread,memwrite,memtoreg,irwrite,alusrca,
    //  regwrite,regdst,pcsource,aluop,alusrcb}
    assign outs = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg,
                   irwrite, alusrca, regwrite, regdst, pcsource, aluop, alusrcb};

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'h00;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'h3f;
        repeat (2) begin
            @(posedge clk); #1;
            total++;
            if (outs !== 16'h0000 || illegal !== 1'b0) begin
                bad++;
                $display("FAIL reset_outs: got %h/%b want 0000/0", outs, illegal);
            end
            total++;
            if (state !== 4'd0 || instret !== 32'd0) begin
                bad++;
                $display("FAIL reset_state: got st=%0d ir=%0d want 0/0", state, instret);
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || outs !== 16'h9201) begin
            bad++;
            $display("FAIL reset_first_fetch: got st=%0d outs=%h want 0/9201", state, outs);
        end
    endtask

    task automatic test_rtype();
        vec_t v[5] = '{
            '{1'b1, 6'h00, 4'd0, 16'h9201, 1'b0, 32'd0},
            '{1'b1, 6'h00, 4'd1, 16'h0003, 1'b0, 32'd0},
            '{1'b1, 6'h2b, 4'd6, 16'h0108, 1'b0, 32'd0},
            '{1'b0, 6'h3f, 4'd7, 16'h00C0, 1'b0, 32'd0},
            '{1'b0, 6'h00, 4'd0, 16'h1001, 1'b0, 32'd1}
        };
        do_reset();
        foreach (v[i]) begin
            mem_ready = v[i].rdy; opcode = v[i].op; #1;
            total++;
            if (state !== v[i].st) begin bad++; $display("FAIL rtype_state c%0d: got %0d want %0d", i, state, v[i].st); end
            total++;
            if (outs !== v[i].outs) begin bad++; $display("FAIL rtype_outs c%0d: got %h want %h", i, outs, v[i].outs); end
            total++;
            if (illegal !== v[i].ill) begin bad++; $display("FAIL rtype_illegal c%0d: got %b want %b", i, illegal, v[i].ill); end
            total++;
            if (instret !== v[i].ir) begin bad++; $display("FAIL rtype_instret c%0d: got %h want %h", i, instret, v[i].ir); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        vec_t v[8] = '{
            '{1'b1, 6'h23, 4'd0, 16'h9201, 1'b0, 32'd0},
            '{1'b1, 6'h23, 4'd1, 16'h0003, 1'b0, 32'd0},
            '{1'b1, 6'h23, 4'd2, 16'h0102, 1'b0, 32'd0},
            '{1'b0, 6'h00, 4'd3, 16'h3000, 1'b0, 32'd0},
            '{1'b0, 6'h00, 4'd3, 16'h3000, 1'b0, 32'd0},
            '{1'b1, 6'h2b, 4'd3, 16'h3000, 1'b0, 32'd0},
            '{1'b0, 6'h00, 4'd4, 16'h0480, 1'b0, 32'd0},
            '{1'b0, 6'h00, 4'd0, 16'h1001, 1'b0, 32'd1}
        };
        do_reset();
        foreach (v[i]) begin
            mem_ready = v[i].rdy; opcode = v[i].op; #1;
            total++;
            if (state !== v[i].st) begin bad++; $display("FAIL lw_state c%0d: got %0d want %0d", i, state, v[i].st); end
            total++;
            if (outs !== v[i].outs) begin bad++; $display("FAIL lw_outs c%0d: got %h want %h", i, outs, v[i].outs); end
            total++;
            if (instret !== v[i].ir) begin bad++; $display("FAIL lw_instret c%0d: got %h want %h", i, instret, v[i].ir); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_reset();
        vec_t v[5] = '{
            '{1'b1, 6'h2b, 4'd0, 16'h9201, 1'b0, 32'd0},
            '{1'b1, 6'h2b, 4'd1, 16'h0003, 1'b0, 32'd0},
            '{1'b1, 6'h2b, 4'd2, 16'h0102, 1'b0, 32'd0},
            '{1'b0, 6'h00, 4'd5, 16'h2800, 1'b0, 32'd0},
            '{1'b0, 6'h00, 4'd5, 16'h2800, 1'b0, 32'd0}
        };
        do_reset();
        foreach (v[i]) begin
            mem_ready = v[i].rdy; opcode = v[i].op; #1;
            total++;
            if (state !== v[i].st) begin bad++; $display("FAIL sw_state c%0d: got %0d want %0d", i, state, v[i].st); end
            total++;
            if (outs !== v[i].outs) begin bad++; $display("FAIL sw_outs c%0d: got %h want %h", i, outs, v[i].outs); end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (memwrite !== 1'b0 || outs !== 16'h0000) begin
            bad++;
            $display("FAIL sw_reset_memwrite: got mw=%b outs=%h want 0/0000", memwrite, outs);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || instret !== 32'd0) begin
            bad++;
            $display("FAIL sw_after_reset: got st=%0d ir=%h want 0/0", state, instret);
        end
    endtask

    task automatic test_fetch_wait();
        vec_t v[7] = '{
            '{1'b0, 6'h04, 4'd0, 16'h1001, 1'b0, 32'd0},
            '{1'b0, 6'h04, 4'd0, 16'h1001, 1'b0, 32'd0},
            '{1'b0, 6'h04, 4'd0, 16'h1001, 1'b0, 32'd0},
            '{1'b1, 6'h04, 4'd0, 16'h9201, 1'b0, 32'd0},
            '{1'b1, 6'h04, 4'd1, 16'h0003, 1'b0, 32'd0},
            '{1'b1, 6'h3f, 4'd8, 16'h4114, 1'b0, 32'd0},
            '{1'b0, 6'h00, 4'd0, 16'h1001, 1'b0, 32'd1}
        };
        do_reset();
        foreach (v[i]) begin
            mem_ready = v[i].rdy; opcode = v[i].op; #1;
            total++;
            if (state !== v[i].st) begin bad++; $display("FAIL fetchwait_state c%0d: got %0d want %0d", i, state, v[i].st); end
            total++;
            if (outs !== v[i].outs) begin bad++; $display("FAIL fetchwait_outs c%0d: got %h want %h", i, outs, v[i].outs); end
            total++;
            if (instret !== v[i].ir) begin bad++; $display("FAIL fetchwait_instret c%0d: got %h want %h", i, instret, v[i].ir); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_addi();
        vec_t v[8] = '{
            '{1'b1, 6'h3f, 4'd0,  16'h9201, 1'b0, 32'd0},
            '{1'b1, 6'h3f, 4'd1,  16'h0003, 1'b1, 32'd0},
            '{1'b1, 6'h3f, 4'd0,  16'h9201, 1'b0, 32'd0},
            '{1'b1, 6'h08, 4'd1,  16'h0003, 1'b0, 32'd0},
            '{1'b1, 6'h3f, 4'd10, 16'h0102, 1'b0, 32'd0},
            '{1'b1, 6'h3f, 4'd11, 16'h0080, 1'b0, 32'd0},
            '{1'b1, 6'h3f, 4'd0,  16'h9201, 1'b0, 32'd1},
            '{1'b0, 6'h00, 4'd1,  16'h0003, 1'b0, 32'd1}
        };
        do_reset();
        foreach (v[i]) begin
            mem_ready = v[i].rdy; opcode = v[i].op; #1;
            total++;
            if (state !== v[i].st) begin bad++; $display("FAIL illaddi_state c%0d: got %0d want %0d", i, state, v[i].st); end
            total++;
            if (outs !== v[i].outs) begin bad++; $display("FAIL illaddi_outs c%0d: got %h want %h", i, outs, v[i].outs); end
            total++;
            if (illegal !== v[i].ill) begin bad++; $display("FAIL illaddi_illegal c%0d: got %b want %b", i, illegal, v[i].ill); end
            total++;
            if (instret !== v[i].ir) begin bad++; $display("FAIL illaddi_instret c%0d: got %h want %h", i, instret, v[i].ir); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back_j_wrap();
        vec_t v[7] = '{
            '{1'b1, 6'h02, 4'd0, 16'h9201, 1'b0, 32'hFFFF_FFFE},
            '{1'b1, 6'h02, 4'd1, 16'h0003, 1'b0, 32'hFFFF_FFFE},
            '{1'b1, 6'h23, 4'd9, 16'h8020, 1'b0, 32'hFFFF_FFFE},
            '{1'b1, 6'h02, 4'd0, 16'h9201, 1'b0, 32'hFFFF_FFFF},
            '{1'b1, 6'h02, 4'd1, 16'h0003, 1'b0, 32'hFFFF_FFFF},
            '{1'b1, 6'h2b, 4'd9, 16'h8020, 1'b0, 32'hFFFF_FFFF},
            '{1'b0, 6'h00, 4'd0, 16'h1001, 1'b0, 32'h0000_0000}
        };
        do_reset();
        // Counting to 2^32 in simulation is impractical; seed the counter instead.
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        foreach (v[i]) begin
            mem_ready = v[i].rdy; opcode = v[i].op; #1;
            total++;
            if (state !== v[i].st) begin bad++; $display("FAIL jwrap_state c%0d: got %0d want %0d", i, state, v[i].st); end
            total++;
            if (outs !== v[i].outs) begin bad++; $display("FAIL jwrap_outs c%0d: got %h want %h", i, outs, v[i].outs); end
            total++;
            if (instret !== v[i].ir) begin bad++; $display("FAIL jwrap_instret c%0d: got %h want %h", i, instret, v[i].ir); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'h00;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_reset();
        test_fetch_wait();
        test_illegal_addi();
        test_back_to_back_j_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit that sequences the processor's shared datapath (ALU, register file, byte-wide memory, PC adders) over several clock cycles per instruction. It replaces the single-cycle decode-only `control` with a Moore state machine, and adds a memory wait-state handshake and a retired-instruction counter. It sits between the instruction register's opcode field and every datapath mux select and write strobe.

## Interface
- No parameters.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `opcode` input 6: instruction bits 31:26 from the instruction register.
- `mem_ready` input 1: memory completes the current read/write this cycle.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `memtoreg`, `irwrite`, `alusrca`, `regwrite`, `regdst` output 1 each: datapath strobes and selects.
- `pcsource` output 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `aluop` output 2: to `alucont`. 00 = add, 01 = sub, 10 = funct.
- `alusrcb` output 2: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `illegal` output 1: one-cycle pulse on an unsupported opcode.
- `instret` output 32: count of retired instructions.
- `state` output 4: current state, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Encodings 12–15 go to FETCH on the next edge with all outputs 0.
- Per-state outputs (any output not listed is 0):
  - FETCH: memread=1, alusrcb=01. irwrite=1 and pcwrite=1 only when mem_ready=1.
  - DECODE: alusrcb=11.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10.
  - MEMRD: memread=1, iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: memwrite=1, iord=1.
  - EXEC: alusrca=1, aluop=10.
  - RWB: regwrite=1, regdst=1.
  - BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
  - JUMP: pcwrite=1, pcsource=10.
  - ADDIWB: regwrite=1.
- Transitions:
  - FETCH goes to DECODE when mem_ready=1, else stays in FETCH.
  - DECODE branches on opcode: lw/sw to MEMADR, R-type to EXEC, beq to BRANCH, j to JUMP, addi to ADDIEX.
  - DECODE with any other opcode goes to FETCH with illegal=1 for that cycle.
  - MEMADR goes to MEMRD for lw, MEMWR for sw.
  - MEMRD goes to MEMWB when mem_ready=1, else holds.
  - MEMWR goes to FETCH when mem_ready=1, else holds. memwrite stays asserted while holding.
  - EXEC to RWB. ADDIEX to ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH and JUMP each go to FETCH.
- instret increments by 1 on each edge that leaves MEMWB, MEMWR (with mem_ready=1), RWB, ADDIWB, BRANCH or JUMP. It wraps from FFFFFFFF to 0. Illegal opcodes do not increment it.
- opcode is sampled only in DECODE and MEMADR; it is ignored in all other states.

## Timing
- Outputs are pure decode of the state register (Moore), except the FETCH irwrite/pcwrite gating by mem_ready.
- While reset=1, every output is 0 regardless of state. This includes memwrite, even if the state register holds MEMWR.
- On the edge with reset=1: state←FETCH and instret←0. The first cycle after reset deasserts is FETCH.
- Reset mid-instruction abandons the instruction with no increment.
- Latency with mem_ready held at 1: beq 3 cycles, j 3, R-type 4, addi 4, sw 4, lw 5.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- When reset and mem_ready are both high in the same cycle, reset wins.

## Structure
- Shared package `mc_pkg` holds:
  - state encodings;
  - opcode constants;
  - `pcsource`, `alusrcb` and `aluop` code constants.
  `alucont` also uses the aluop codes.
- One sub-module, `mc_outdec`: the combinational state-to-outputs decoder.
- The top level holds the state register, next-state logic and the instret counter.

## Test plan
- Reset, then R-type (000000) with mem_ready=1: state sequence 0,1,6,7,0. regdst=1 and regwrite=1 in state 7. instret=1 after 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0. memread=1, iord=1 held for 3 cycles. instret=1 after 7 cycles.
- sw (101011) with reset asserted while in MEMWR: memwrite=0 during reset. Next state is 0 and instret=0.
- FETCH with mem_ready=0 for 3 cycles: irwrite=0 and pcwrite=0 for those 3 cycles. Both go to 1 in the ready cycle, then state=1.
- Opcode 111111 in DECODE: illegal=1 for exactly one cycle, next state 0, instret unchanged.
- Preload instret=FFFFFFFF via a back-to-back j stream: the next retire wraps it to 00000000. Each j takes 3 cycles with pcsource=10 in state 9.
